// File: rtl/param_fifo_pkg.sv
// Shared defaults and helpers for the parameterised FIFO.
package param_fifo_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 128;
  localparam int DEFAULT_AE_LEVEL = 4;
  // almost_full sits this many entries below DEPTH by default
  localparam int DEFAULT_AF_GAP   = 4;

  // Occupancy needs one more bit than the pointers so that DEPTH itself fits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, read either asynchronous
// (ASYNC_READ=1, output forced to zero while re is low) or registered on re.
module fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never reset, only made unreachable by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (ASYNC_READ) begin : g_async
      assign rdata = re ? mem[raddr] : '0;
    end else begin : g_sync
      logic [WIDTH-1:0] rdata_q;
      // Registered read; a same-address write in this cycle returns the old word.
      always_ff @(posedge clk) begin
        if (re) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with occupancy flags and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through output; the default
// build uses a registered output that updates one cycle after each pop.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEFAULT_AF_GAP,
  parameter int AE_LEVEL = DEFAULT_AE_LEVEL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  input  logic                        pop,
  output logic [WIDTH-1:0]            dout,
  output logic                        dout_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             ovf_q, udf_q;
  logic             push_acc, pop_acc;
  logic             ram_re;
  logic [WIDTH-1:0] ram_rdata;

  // Flags come from the registered count only.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A pop frees a slot in the same cycle, so push into full succeeds alongside it.
  assign pop_acc  = pop && !empty && !clr;
  assign push_acc = push && (!full || pop_acc) && !clr;

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_acc) ovf_q <= 1'b1;
      if (pop && empty)      udf_q <= 1'b1;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  localparam bit ASYNC_RD = 1'b1;

  // Head entry is always on dout; zero when nothing is stored.
  assign ram_re     = !empty;
  assign dout       = ram_rdata;
  assign dout_valid = !empty;
`else
  localparam bit ASYNC_RD = 1'b0;

  logic dout_valid_q;
  logic dout_seen;

  assign ram_re = pop_acc;

  // dout_valid pulses for the cycle after a pop; dout_seen masks the
  // unloaded read register so dout reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      dout_seen    <= 1'b0;
    end else if (clr) begin
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= pop_acc;
      if (pop_acc) dout_seen <= 1'b1;
    end
  end

  assign dout       = dout_seen ? ram_rdata : '0;
  assign dout_valid = dout_valid_q;
`endif

  fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ASYNC_READ (ASYNC_RD)
  ) u_ram (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (WIDTH=8, DEPTH=8, AF=6, AE=2) with a queue
// scoreboard and a small reference model of count, flags and error flags.
module tb_param_fifo;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst, clr, push, pop;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         dout_valid, full, empty, almost_full, almost_empty;
  logic [3:0]   count;
  logic         overflow, underflow;

  param_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .push         (push),
    .din          (din),
    .pop          (pop),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sb[$];
  logic         m_ovf, m_udf, m_dv;
  logic [W-1:0] m_dout;
  int           total = 0;
  int           bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = sb.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == D));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
`ifdef PARAM_FIFO_FWFT_EN
    check("dout_valid", 32'(dout_valid), 32'(n > 0));
    if (n > 0) check("dout_head", 32'(dout), 32'(sb[0]));
    else       check("dout_empty", 32'(dout), 32'(0));
`else
    check("dout_valid", 32'(dout_valid), 32'(m_dv));
    check("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  // One clock with the given inputs; the model is advanced with the same rules.
  task automatic cycle(input logic p, input logic [W-1:0] d, input logic q, input logic c);
    logic pop_ok, push_ok;
    int   n0;
    push = p; din = d; pop = q; clr = c;
    n0      = sb.size();
    pop_ok  = q && !c && (n0 > 0);
    push_ok = p && !c && ((n0 < D) || pop_ok);
    @(posedge clk);
    #1;
    if (c) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dv  = 1'b0;
    end else begin
      if (pop_ok) m_dout = sb.pop_front();
      if (push_ok) sb.push_back(d);
      if (p && !push_ok) m_ovf = 1'b1;
      if (q && n0 == 0) m_udf = 1'b1;
      m_dv = pop_ok;
    end
    push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
    check_state();
  endtask

  // Reset while every other input is active: reset must win.
  task automatic do_reset();
    rst = 1'b1; push = 1'b1; din = 8'h77; pop = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
    sb.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = '0;
    check_state();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    // Overflow: 0xAA must be dropped
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    // Full push+pop: old head 0x01 returned, 0x09 enters at the tail
    cycle(1'b1, 8'h09, 1'b1, 1'b0);
    // Drain: 0x02..0x09, never 0xAA
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow on empty, then push+pop on empty accepts only the push
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Interleaved push/pop pairs across pointer wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with count 5 and overflow set; push/pop during clr are ignored
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-stream discards stored entries
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
